// File: rtl/imem_ctrl.sv
// Instruction-memory controller: serves core fetches from a one-entry last-fetch buffer
// or an external req/ack word memory, answering misaligned or timed-out fetches with a NOP.
module imem_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        instr_req,
  input  logic [31:0] instr_adr,
  output logic [31:0] instr_read,
  output logic        instr_valid,
  output logic        mem_req,
  output logic [29:0] mem_adr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] read_q, read_d;
  logic        req_q, req_d;
  logic [29:0] adr_q, adr_d;
  logic        err_q, err_d;
  logic        buf_v_q, buf_v_d;
  logic [29:0] buf_adr_q, buf_adr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [7:0]  cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    req_d      = req_q;
    adr_d      = adr_q;
    err_d      = err_q;
    buf_v_d    = buf_v_q;
    buf_adr_d  = buf_adr_q;
    buf_data_d = buf_data_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (instr_req) begin
          if (instr_adr[1:0] != 2'b00) begin
            read_d  = NOP;
            err_d   = 1'b1;
            state_d = StDone;
          end else if (buf_v_q && (buf_adr_q == instr_adr[31:2])) begin
            read_d  = buf_data_q;
            state_d = StDone;
          end else begin
            adr_d   = instr_adr[31:2];
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        // An ack in the last allowed cycle wins over the timeout.
        if (mem_ack) begin
          read_d     = mem_rdata;
          buf_adr_d  = adr_q;
          buf_data_d = mem_rdata;
          buf_v_d    = 1'b1;
          req_d      = 1'b0;
          state_d    = StDone;
        end else if (cnt_q == CntLast) begin
          read_d  = NOP;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q    <= StIdle;
      read_q     <= 32'd0;
      req_q      <= 1'b0;
      adr_q      <= 30'd0;
      err_q      <= 1'b0;
      buf_v_q    <= 1'b0;
      buf_adr_q  <= 30'd0;
      buf_data_q <= 32'd0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      req_q      <= req_d;
      adr_q      <= adr_d;
      err_q      <= err_d;
      buf_v_q    <= buf_v_d;
      buf_adr_q  <= buf_adr_d;
      buf_data_q <= buf_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign instr_read  = read_q;
  assign instr_valid = (state_q == StDone);
  assign mem_req     = req_q;
  assign mem_adr     = adr_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl: expected fetch results are queued at request time and
// checked when instr_valid strobes; bus activity and latency are checked per fetch.
module tb_imem_ctrl;

  localparam int unsigned TO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_adr = 32'd0;
  logic [31:0] instr_read;
  logic        instr_valid;
  logic        mem_req;
  logic [29:0] mem_adr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        fetch_err;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_ctrl #(.TIMEOUT(TO), .NOP(NOP)) dut (
    .CLK        (CLK),
    .RES        (RES),
    .instr_req  (instr_req),
    .instr_adr  (instr_adr),
    .instr_read (instr_read),
    .instr_valid(instr_valid),
    .mem_req    (mem_req),
    .mem_adr    (mem_adr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .fetch_err  (fetch_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid strobe must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RES && instr_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("instr_read", instr_read, e.data);
        check_eq("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
      end
    end
  end

  // ack_at < 0: never acknowledge. exp_req: number of cycles mem_req must be high.
  task automatic fetch(input logic [31:0] adr, input int ack_at, input logic [31:0] rdata,
                       input int exp_valid, input int exp_req, input logic [31:0] exp_data,
                       input logic exp_err);
    int   req_cycles;
    bit   seen;
    exp_t e;
    req_cycles = 0;
    seen       = 1'b0;
    e.data = exp_data;
    e.err  = exp_err;
    exp_q.push_back(e);
    mem_rdata = rdata;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge CLK);
      #1;
      instr_req = (c == 0);
      instr_adr = (c == 0) ? adr : 32'hDEAD_BEEC;
      mem_ack   = (c == ack_at);
      @(negedge CLK);
      if (mem_req) begin
        if (req_cycles == 0) check_eq("mem_adr", {2'b00, mem_adr}, {2'b00, adr[31:2]});
        req_cycles++;
      end
      if (instr_valid) begin
        seen = 1'b1;
        check_eq("valid_cycle", c, exp_valid);
      end
    end
    if (!seen) check_eq("valid_seen", 32'd0, 32'd1);
    check_eq("mem_req_cycles", req_cycles, exp_req);
    mem_ack = 1'b0;
  endtask

  initial begin
    #3;
    check_eq("rst_instr_read", instr_read, 32'd0);
    check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_adr", {2'b00, mem_adr}, 32'd0);
    check_eq("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    @(posedge CLK);
    #1 RES = 1'b0;

    fetch(32'h0, 3, 32'h0050_0093, 4, 3, 32'h0050_0093, 1'b0);  // miss
    fetch(32'h0, -1, 32'h0, 1, 0, 32'h0050_0093, 1'b0);         // hit
    fetch(32'h4, 1, 32'h0020_81B3, 2, 1, 32'h0020_81B3, 1'b0);  // miss, replaces entry
    fetch(32'h0, 2, 32'h0050_0093, 3, 2, 32'h0050_0093, 1'b0);  // miss again
    fetch(32'h6, 1, 32'hFFFF_FFFF, 1, 0, NOP, 1'b1);            // misaligned
    fetch(32'h0, -1, 32'h0, 1, 0, 32'h0050_0093, 1'b1);         // error stays sticky

    // Reset in cycle 2 of a miss.
    @(posedge CLK);
    #1 instr_req = 1'b1; instr_adr = 32'h40;
    @(posedge CLK);
    #1 instr_req = 1'b0;
    @(posedge CLK);
    #2 RES = 1'b1;
    #1;
    check_eq("async_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("async_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("async_err", {31'd0, fetch_err}, 32'd0);
    @(posedge CLK);
    #1 RES = 1'b0;
    repeat (3) @(posedge CLK);

    fetch(32'h0, TO, 32'h0050_0093, TO + 1, TO, 32'h0050_0093, 1'b0);  // buffer invalidated
    fetch(32'h40, -1, 32'h1234_5678, TO + 1, TO, NOP, 1'b1);          // timeout

    // Ack while idle must do nothing.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1 mem_ack = 1'b1; mem_rdata = 32'hCAFE_0000 + i;
      @(negedge CLK);
      check_eq("idle_ack_req", {31'd0, mem_req}, 32'd0);
    end
    @(posedge CLK);
    #1 mem_ack = 1'b0;

    fetch(32'h0, -1, 32'h0, 1, 0, 32'h0050_0093, 1'b1);  // hit: timeout left buffer alone

    repeat (2) @(posedge CLK);
    check_eq("pending_expect", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
